rv_multicycle_ctrl: RTL and testbench

Multi-cycle sequencing controller for the reduced RISC-V core. It drives instruction fetch from a variable-latency instruction memory and latches the fetched word into the instruction register. It then steps each instruction through decode, execute and writeback, generating the datapath selects consumed by the register file, ALU, PC logic and immediate sign-extender (`ImmSrc`). Supported instructions are `addi` and `bne`; anything else halts the core with a sticky `illegal` flag.

---
 rtl/rv_multicycle_ctrl_if.sv | 31 +++
 rtl/rv_multicycle_ctrl.sv | 160 ++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rv_multicycle_ctrl_if.sv
// Handshake and control bundle between the multi-cycle controller and the rest of the core.
// The master side is the controller; the slave side is memory plus the datapath.
interface rv_multicycle_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr;
  logic                  EQ;
  logic                  imem_req;
  logic                  IRWrite;
  logic                  PCWrite;
  logic                  PCsrc;
  logic                  ImmSrc;
  logic                  ALUsrc;
  logic [2:0]            ALUctrl;
  logic                  RegWrite;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] retire_cnt;

  modport master (
    input  instr_valid, instr, EQ,
    output imem_req, IRWrite, PCWrite, PCsrc, ImmSrc, ALUsrc, ALUctrl,
           RegWrite, illegal, retire_cnt
  );

  modport slave (
    output instr_valid, instr, EQ,
    input  imem_req, IRWrite, PCWrite, PCsrc, ImmSrc, ALUsrc, ALUctrl,
           RegWrite, illegal, retire_cnt
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle sequencer for the reduced RISC-V core: fetch, decode, execute and writeback
// of addi and bne, with a sticky halt on anything else and a retired-instruction counter.
module rv_multicycle_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rv_multicycle_ctrl_if.master  bus
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADDI   = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC_I = 3'd3,
    WB     = 3'd4,
    EXEC_B = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t                state_q,      state_d;
  logic                  armed_q,      armed_d;
  logic [6:0]            opcode_q,     opcode_d;
  logic [2:0]            funct3_q,     funct3_d;
  logic                  illegal_q,    illegal_d;
  logic [DATA_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

  logic fetch_done;
  logic retire;

  assign fetch_done = (state_q == FETCH) && bus.instr_valid;
  assign retire     = (state_q == WB) || (state_q == EXEC_B);

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      opcode_q     <= '0;
      funct3_q     <= '0;
      illegal_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      opcode_q     <= opcode_d;
      funct3_q     <= funct3_d;
      illegal_q    <= illegal_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // ---------------------------------------------------------------- next state
  // armed_q makes IDLE last one full cycle after reset release, so the first
  // FETCH starts on the second rising edge regardless of where rst_n rose.
  always_comb begin
    state_d = state_q;
    armed_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (armed_q) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.instr_valid) begin
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (opcode_q == OP_IMM && funct3_q == F3_ADDI) begin
          state_d = EXEC_I;
        end else if (opcode_q == OP_BRANCH && funct3_q == F3_BNE) begin
          state_d = EXEC_B;
        end else begin
          state_d = HALT;
        end
      end
      EXEC_I:  state_d = WB;
      WB:      state_d = FETCH;
      EXEC_B:  state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // ---------------------------------------------------------------- captured fields and counters
  always_comb begin
    opcode_d     = opcode_q;
    funct3_d     = funct3_q;
    illegal_d    = illegal_q;
    retire_cnt_d = retire_cnt_q;

    if (fetch_done) begin
      opcode_d = bus.instr[6:0];
      funct3_d = bus.instr[14:12];
    end

    if (state_d == HALT) begin
      illegal_d = 1'b1;
    end

    // Counter wraps naturally at all-ones.
    if (retire) begin
      retire_cnt_d = retire_cnt_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    bus.imem_req = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.PCsrc    = 1'b0;
    bus.ImmSrc   = 1'b0;
    bus.ALUsrc   = 1'b0;
    bus.ALUctrl  = ALU_ADD;
    bus.RegWrite = 1'b0;

    unique case (state_q)
      FETCH: begin
        bus.imem_req = 1'b1;
        bus.IRWrite  = bus.instr_valid;
      end
      EXEC_I: begin
        bus.ImmSrc  = 1'b0;
        bus.ALUsrc  = 1'b1;
        bus.ALUctrl = ALU_ADD;
      end
      WB: begin
        // ALU operands held from EXEC_I so the write-back data stays stable.
        bus.RegWrite = 1'b1;
        bus.PCWrite  = 1'b1;
        bus.PCsrc    = 1'b0;
        bus.ALUsrc   = 1'b1;
        bus.ALUctrl  = ALU_ADD;
      end
      EXEC_B: begin
        bus.ImmSrc  = 1'b1;
        bus.ALUsrc  = 1'b0;
        bus.ALUctrl = ALU_SUB;
        bus.PCWrite = 1'b1;
        bus.PCsrc   = ~bus.EQ;
      end
      default: begin
      end
    endcase

    bus.illegal    = illegal_q;
    bus.retire_cnt = retire_cnt_q;
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_rv_multicycle_ctrl;

  localparam int DW = 32;

  // Output vector layout: {imem_req, IRWrite, PCWrite, PCsrc, ImmSrc, ALUsrc, ALUctrl[2:0], RegWrite, illegal}
  localparam logic [10:0] E_ZERO   = 11'b0_0_0_0_0_0_000_0_0;
  localparam logic [10:0] E_FETCH  = 11'b1_0_0_0_0_0_000_0_0;
  localparam logic [10:0] E_FETCHV = 11'b1_1_0_0_0_0_000_0_0;
  localparam logic [10:0] E_EXI    = 11'b0_0_0_0_0_1_000_0_0;
  localparam logic [10:0] E_WB     = 11'b0_0_1_0_0_1_000_1_0;
  localparam logic [10:0] E_BNE_T  = 11'b0_0_1_1_1_0_001_0_0;
  localparam logic [10:0] E_BNE_N  = 11'b0_0_1_0_1_0_001_0_0;
  localparam logic [10:0] E_HALT   = 11'b0_0_0_0_0_0_000_0_1;

  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_BNE  = 32'hFE20_9EE3;
  localparam logic [31:0] I_ILL  = 32'h0000_0033;

  typedef struct {
    int          cyc;
    string       name;
    logic [10:0] out;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  rv_multicycle_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  rv_multicycle_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] dut_vec();
    return {bus.imem_req, bus.IRWrite, bus.PCWrite, bus.PCsrc, bus.ImmSrc,
            bus.ALUsrc, bus.ALUctrl, bus.RegWrite, bus.illegal};
  endfunction

  task automatic compare(input string name, input logic [10:0] exp_out, input logic [31:0] exp_cnt);
    logic [10:0] got;
    got = dut_vec();
    n_checks++;
    if (got !== exp_out || bus.retire_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL %s: got outputs=%b cnt=%0d, required outputs=%b cnt=%0d",
               name, got, bus.retire_cnt, exp_out, exp_cnt);
    end else begin
      $display("ok   %-14s outputs=%b cnt=%0d", name, got, bus.retire_cnt);
    end
  endtask

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: stale expectation for cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
      end else begin
        compare(e.name, e.out, e.cnt);
      end
    end
  end

  // Queue the expected outputs for the current cycle, then advance to just after the next edge.
  task automatic expect_cycle(input string name, input logic [10:0] out, input logic [31:0] cnt);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.out  = out;
    e.cnt  = cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic addi_zero_wait(input logic [31:0] cnt);
    bus.instr_valid = 1'b1; bus.instr = I_ADDI;
    expect_cycle("addi_fetch", E_FETCHV, cnt);
    bus.instr_valid = 1'b0;
    expect_cycle("addi_decode", E_ZERO, cnt);
    expect_cycle("addi_exec", E_EXI, cnt);
    expect_cycle("addi_wb", E_WB, cnt);
  endtask

  task automatic bne_zero_wait(input logic eq, input logic [31:0] cnt);
    bus.instr_valid = 1'b1; bus.instr = I_BNE; bus.EQ = eq;
    expect_cycle("bne_fetch", E_FETCHV, cnt);
    bus.instr_valid = 1'b0;
    expect_cycle("bne_decode", E_ZERO, cnt);
    expect_cycle(eq ? "bne_exec_eq" : "bne_exec_ne", eq ? E_BNE_N : E_BNE_T, cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.EQ = 1'b0;
    @(posedge clk);
    #1;

    // Reset held for 3 cycles, with a stray instr_valid that must be ignored.
    bus.instr_valid = 1'b1; bus.instr = I_ADDI;
    for (int i = 0; i < 3; i++) expect_cycle("in_reset", E_ZERO, 0);
    bus.instr_valid = 1'b0;
    rst_n = 1'b1;
    expect_cycle("idle_a", E_ZERO, 0);
    expect_cycle("idle_b", E_ZERO, 0);

    // Zero-wait addi, then bne not-taken-equal / taken.
    addi_zero_wait(0);
    bne_zero_wait(1'b0, 1);
    bne_zero_wait(1'b1, 2);

    // Memory stall: valid arrives 3 cycles after imem_req rises.
    bus.instr = I_ADDI;
    for (int i = 0; i < 3; i++) expect_cycle("stall_fetch", E_FETCH, 3);
    bus.instr_valid = 1'b1;
    expect_cycle("stall_fetchv", E_FETCHV, 3);
    bus.instr = I_ILL;  // spurious pulse in DECODE must neither strobe nor redirect
    expect_cycle("spur_decode", E_ZERO, 3);
    bus.instr_valid = 1'b0;
    expect_cycle("stall_exec", E_EXI, 3);
    expect_cycle("stall_wb", E_WB, 3);

    // Illegal opcode halts; instr_valid in HALT is ignored.
    bus.instr_valid = 1'b1; bus.instr = I_ILL;
    expect_cycle("ill_fetch", E_FETCHV, 4);
    bus.instr_valid = 1'b0;
    expect_cycle("ill_decode", E_ZERO, 4);
    for (int i = 0; i < 22; i++) begin
      bus.instr_valid = i[0];
      bus.instr = I_ADDI;
      expect_cycle("halt", E_HALT, 4);
    end
    bus.instr_valid = 1'b0;

    // Reset clears illegal and the counter.
    rst_n = 1'b0;
    #1;
    compare("halt_reset", E_ZERO, 0);
    expect_cycle("halt_in_reset", E_ZERO, 0);
    rst_n = 1'b1;
    expect_cycle("idle_c", E_ZERO, 0);
    expect_cycle("idle_d", E_ZERO, 0);

    // Retire one bne, then drop reset in the middle of an addi WB.
    bne_zero_wait(1'b0, 0);
    bus.instr_valid = 1'b1; bus.instr = I_ADDI;
    expect_cycle("addi2_fetch", E_FETCHV, 1);
    bus.instr_valid = 1'b0;
    expect_cycle("addi2_decode", E_ZERO, 1);
    expect_cycle("addi2_exec", E_EXI, 1);
    compare("wb_before_rst", E_WB, 1);
    #2;
    rst_n = 1'b0;
    #1;
    compare("wb_after_rst", E_ZERO, 0);
    @(posedge clk);
    #1;
    compare("wb_rst_edge", E_ZERO, 0);
    rst_n = 1'b1;

    // Wrap-free sanity after release: addi retires normally again.
    expect_cycle("idle_e", E_ZERO, 0);
    expect_cycle("idle_f", E_ZERO, 0);
    addi_zero_wait(0);
    expect_cycle("post_fetch", E_FETCH, 1);

    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
